// File: rtl/micro80_uart_pkg.sv
// Shared definitions for the Micro-80 UART receive and transmit paths.
`timescale 1ns / 1ps
package micro80_uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} rx_state_e;

    localparam int unsigned STAT_AVAIL     = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_OVERRUN   = 2;
    localparam int unsigned STAT_FRAME_ERR = 3;
    localparam int unsigned STAT_BUSY      = 4;

    // Clock cycles per oversample tick.
    function automatic int unsigned uart_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        return clk_hz / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_port_if.sv
// CPU/line-facing signals of the UART receive port.
`timescale 1ns / 1ps
interface uart_rx_port_if;
    logic       rx;
    logic       pop;
    logic       clr_err;
    logic [7:0] DO;
    logic [7:0] STATUS;
    logic       bsy;

    modport master (output rx, pop, clr_err, input DO, STATUS, bsy);
    modport slave (input rx, pop, clr_err, output DO, STATUS, bsy);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding received bytes; reads 8'hFF when empty.
`timescale 1ns / 1ps
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   count_q;
    logic             wr_en;
    logic             rd_en;

    assign full  = count_q == (PTR_W + 1)'(DEPTH);
    assign empty = count_q == '0;
    // A pop on the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            count_q <= count_q + (PTR_W + 1)'(wr_en) - (PTR_W + 1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= din;
    end

    assign dout  = empty ? 8'hFF : mem[rptr];
    assign count = count_q;

endmodule

// File: rtl/uart_rx_port.sv
// Micro-80 UART receiver: synchronizer, oversampling 8N1 deframer, FIFO and status flags.
`timescale 1ns / 1ps
module uart_rx_port
    import micro80_uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVS        = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           rst,
    uart_rx_port_if.slave bus
);
    localparam int unsigned DIV   = uart_div(CLK_HZ, BAUD, OVS);
    localparam int unsigned DIV_W = $clog2(DIV);
    localparam int unsigned S_W   = $clog2(OVS);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(OVS - 1);
    localparam logic [S_W-1:0]   S_MAJ0   = S_W'(OVS / 2 - 1);
    localparam logic [S_W-1:0]   S_MAJ1   = S_W'(OVS / 2);
    localparam logic [S_W-1:0]   S_MAJ2   = S_W'(OVS / 2 + 1);

    logic             rx_meta;
    logic             rx_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    rx_state_e        state;
    logic [S_W-1:0]   s_cnt;
    logic [2:0]       bit_cnt;
    logic             smp0;
    logic             smp1;
    logic             maj;
    logic             mid_pt;
    logic [7:0]       shreg;
    logic             bsy_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             start_det;
    logic             push;
    logic             frame_bad;
    logic             ovf;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       status;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    assign start_det = (state == IDLE) && !rx_s;
    assign tick      = div_cnt == DIV_LAST;

    // Restart the divider on the start edge so ticks line up with the bit cell.
    always_ff @(posedge clk) begin
        if (rst || start_det || tick) div_cnt <= '0;
        else                         div_cnt <= div_cnt + 1'b1;
    end

    assign mid_pt    = tick && (s_cnt == S_MAJ2);
    assign maj       = (smp0 & smp1) | (smp0 & rx_s) | (smp1 & rx_s);
    assign push      = (state == STOP) && mid_pt && maj;
    assign frame_bad = (state == STOP) && mid_pt && !maj;
    assign ovf       = push && fifo_full && !bus.pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s_cnt   <= '0;
            bit_cnt <= '0;
            smp0    <= 1'b1;
            smp1    <= 1'b1;
            shreg   <= '0;
            bsy_q   <= 1'b0;
        end else begin
            if (tick) begin
                if (s_cnt == S_MAJ0) smp0 <= rx_s;
                if (s_cnt == S_MAJ1) smp1 <= rx_s;
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                        bsy_q <= 1'b1;
                    end
                end
                START: begin
                    if (mid_pt) begin
                        if (maj) begin
                            state <= IDLE;
                            bsy_q <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                DATA: begin
                    if (mid_pt) begin
                        shreg   <= {maj, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    if (mid_pt) begin
                        if (maj) begin
                            state <= IDLE;
                            bsy_q <= 1'b0;
                        end else begin
                            state <= WAITHI;
                        end
                    end
                end
                WAITHI: begin
                    // A held-low line (break) must not be mistaken for new start bits.
                    if (rx_s) begin
                        state <= IDLE;
                        bsy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    bsy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (frame_bad)        frame_err_q <= 1'b1;
            else if (bus.clr_err) frame_err_q <= 1'b0;
            if (ovf)              overrun_q <= 1'b1;
            else if (bus.clr_err) overrun_q <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (bus.pop),
        .din  (shreg),
        .dout (fifo_dout),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        status                 = 8'hE0;
        status[STAT_BUSY]      = bsy_q;
        status[STAT_FRAME_ERR] = frame_err_q;
        status[STAT_OVERRUN]   = overrun_q;
        status[STAT_FULL]      = fifo_count == CNT_W'(FIFO_DEPTH);
        status[STAT_AVAIL]     = !fifo_empty;
    end

    assign bus.DO     = fifo_dout;
    assign bus.STATUS = status;
    assign bus.bsy    = bsy_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Self-checking bench for uart_rx_port: vector table, corner sequences, random bytes vs a queue model.
`timescale 1ns / 1ps
module tb_uart_rx_port;
    localparam int unsigned CLK_HZ = 7_372_800;  // 4 clocks per tick at 115200 x16
    localparam int unsigned BAUD   = 115200;
    localparam int unsigned OVS    = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int BIT_NS = 640;
    localparam int A_SEND = 0;
    localparam int A_POP  = 1;
    localparam int A_CLR  = 2;

    typedef struct {
        int         act;
        logic [7:0] data;
        logic [7:0] exp_do;
        logic [7:0] exp_st;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_port_if bus ();

    uart_rx_port #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .OVS       (OVS),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0] mq[$];
    bit m_fe;
    bit m_ov;
    bit hit;
    bit seen;
    int t_end;
    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_do();
        return (mq.size() != 0) ? mq[0] : 8'hFF;
    endfunction

    function automatic logic [7:0] exp_status();
        return {3'b111, 1'b0, m_fe, m_ov, mq.size() == DEPTH, mq.size() != 0};
    endfunction

    task automatic model_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ov = 1'b1;
    endtask

    task automatic model_pop();
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic check_model(input string name);
        check({name, "_do"}, bus.DO, exp_do());
        check({name, "_status"}, bus.STATUS, exp_status());
        check({name, "_bsy"}, bus.bsy, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bit_ns, input int stop_ns,
                              input logic stop_val);
        bus.rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            #(bit_ns);
        end
        bus.rx = stop_val;
        #(stop_ns);
        bus.rx = 1'b1;
    endtask

    task automatic send_and_settle(input logic [7:0] b);
        send_frame(b, BIT_NS, BIT_NS, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_strobe();
        @(negedge clk);
        bus.pop = 1'b1;
        @(negedge clk);
        bus.pop = 1'b0;
    endtask

    task automatic clr_strobe();
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        vecs[0]  = '{A_SEND, 8'h55, 8'h55, 8'hE1};
        vecs[1]  = '{A_SEND, 8'hA3, 8'h55, 8'hE1};
        vecs[2]  = '{A_POP,  8'h00, 8'hA3, 8'hE1};
        vecs[3]  = '{A_POP,  8'h00, 8'hFF, 8'hE0};
        vecs[4]  = '{A_POP,  8'h00, 8'hFF, 8'hE0};
        vecs[5]  = '{A_SEND, 8'h01, 8'h01, 8'hE1};
        vecs[6]  = '{A_SEND, 8'h02, 8'h01, 8'hE1};
        vecs[7]  = '{A_SEND, 8'h03, 8'h01, 8'hE1};
        vecs[8]  = '{A_SEND, 8'h04, 8'h01, 8'hE3};
        vecs[9]  = '{A_SEND, 8'h05, 8'h01, 8'hE7};
        vecs[10] = '{A_POP,  8'h00, 8'h02, 8'hE5};
        vecs[11] = '{A_POP,  8'h00, 8'h03, 8'hE5};
        vecs[12] = '{A_POP,  8'h00, 8'h04, 8'hE5};
        vecs[13] = '{A_POP,  8'h00, 8'hFF, 8'hE4};
        vecs[14] = '{A_CLR,  8'h00, 8'hFF, 8'hE0};

        bus.rx = 1'b1;
        bus.pop = 1'b0;
        bus.clr_err = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_do", bus.DO, 8'hFF);
        check("reset_status", bus.STATUS, 8'hE0);
        check("reset_bsy", bus.bsy, 1'b0);

        for (int i = 0; i < 15; i++) begin
            case (vecs[i].act)
                A_SEND:  send_and_settle(vecs[i].data);
                A_POP:   pop_strobe();
                default: clr_strobe();
            endcase
            check($sformatf("vec%0d_do", i), bus.DO, vecs[i].exp_do);
            check($sformatf("vec%0d_status", i), bus.STATUS, vecs[i].exp_st);
            check($sformatf("vec%0d_bsy", i), bus.bsy, 1'b0);
        end

        // Half-bit low glitch on an idle line.
        seen = 1'b0;
        t_end = 200;
        @(negedge clk);
        fork
            begin
                bus.rx = 1'b0;
                #(BIT_NS / 2);
                bus.rx = 1'b1;
            end
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (bus.bsy === 1'b1) seen = 1'b1;
                    if (seen && bus.bsy === 1'b0) begin
                        t_end = i;
                        break;
                    end
                end
            end
        join
        check("glitch_bsy_seen", seen, 1'b1);
        check("glitch_idle_within_bit", t_end < 64, 1'b1);
        repeat (128) @(negedge clk);
        check_model("glitch");

        // Stop bit held low for two bit times.
        send_frame(8'h3C, BIT_NS, 2 * BIT_NS, 1'b0);
        m_fe = 1'b1;
        repeat (4) @(negedge clk);
        check_model("frame_err");
        #(BIT_NS);
        send_and_settle(8'h12);
        model_push(8'h12);
        check_model("after_frame_err");
        clr_strobe();
        m_fe = 1'b0;
        m_ov = 1'b0;
        check_model("frame_err_clr");
        pop_strobe();
        model_pop();
        check_model("frame_err_pop");

        // Full FIFO with a pop landing on the push cycle.
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom_range(0, 255));
            send_and_settle(b);
            model_push(b);
            check_model($sformatf("fill%0d", i));
        end
        hit = 1'b0;
        fork
            send_frame(8'h77, BIT_NS, BIT_NS, 1'b1);
            begin
                for (int i = 0; i < 800 && !hit; i++) begin
                    @(negedge clk);
                    if (dut.push === 1'b1) begin
                        bus.pop = 1'b1;
                        @(negedge clk);
                        bus.pop = 1'b0;
                        hit = 1'b1;
                    end
                end
            end
        join
        check("pop_on_push_seen", hit, 1'b1);
        model_pop();
        model_push(8'h77);
        repeat (4) @(negedge clk);
        check_model("pop_on_push");
        for (int i = 0; i < DEPTH - 1; i++) begin
            pop_strobe();
            model_pop();
            check_model($sformatf("pop_on_push_drain%0d", i));
        end
        check("pop_on_push_last", bus.DO, 8'h77);
        pop_strobe();
        model_pop();
        check_model("pop_on_push_empty");

        // Reset in the middle of data bit 4 with a byte already queued.
        send_and_settle(8'h11);
        model_push(8'h11);
        check_model("pre_rst");
        bus.rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 1'b0;
            #(BIT_NS);
        end
        bus.rx = 1'b1;
        #(BIT_NS / 2);
        @(negedge clk);
        check("rst_mid_busy_before", bus.bsy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_fe = 1'b0;
        m_ov = 1'b0;
        check_model("rst_mid");
        #(2 * BIT_NS);
        send_and_settle(8'hC9);
        model_push(8'hC9);
        check_model("after_rst");
        check("after_rst_byte", bus.DO, 8'hC9);
        pop_strobe();
        model_pop();
        check_model("after_rst_pop");

        // Sender clock skewed by about +3% and -3%, frames back to back.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                send_frame(8'h5A, (k == 0) ? 659 : 621, (k == 0) ? 659 : 621, 1'b1);
                model_push(8'h5A);
            end
            repeat (4) @(negedge clk);
            check_model($sformatf("skew%0d", k));
            for (int i = 0; i < 3; i++) begin
                pop_strobe();
                model_pop();
                check_model($sformatf("skew%0d_pop%0d", k, i));
            end
        end

        // Random bytes, gaps and pops against the queue model.
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom_range(0, 255));
            #($urandom_range(0, 1000));
            send_and_settle(b);
            model_push(b);
            check_model($sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) begin
                pop_strobe();
                model_pop();
                check_model($sformatf("rnd%0d_pop", i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
